// File: rtl/ttc_frame_tx.sv
// TTC frame serializer: emits back-to-back 16-bit frames MSB first on clk160.
// After reset a fixed number of sync frames lock the receiver; afterwards
// command words from a one-deep holding register are interleaved with idle
// sync frames, and a sync frame is forced after SYNC_INTERVAL command frames.
module ttc_frame_tx #(
    parameter logic [15:0] SYNC_WORD     = 16'h817E,
    parameter int          LOCK_FRAMES   = 46,
    parameter int          SYNC_INTERVAL = 32
) (
    input  logic        clk160,
    input  logic        rst,
    input  logic [15:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        ttc_data,
    output logic        frame_start,
    output logic        frame_is_sync,
    output logic        preamble_done
);
    localparam int FCW = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;
    localparam int RCW = (SYNC_INTERVAL > 0) ? $clog2(SYNC_INTERVAL + 1) : 1;
    localparam logic [FCW-1:0] LOCK_CNT = FCW'(LOCK_FRAMES);
    localparam logic [RCW-1:0] RUN_MAX  = RCW'(SYNC_INTERVAL);

    typedef enum logic {PREAMBLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [3:0]      bit_cnt;     // bit being loaded onto ttc_data at the next edge
    logic [15:0]     shreg;       // current frame
    logic [FCW-1:0]  frame_cnt;   // sync frames started during the preamble
    logic [RCW-1:0]  run_cnt;     // consecutive command frames
    logic            hold_full;
    logic [15:0]     hold_data;
    logic            out_en;      // keeps cmd_ready low until the first edge after reset

    logic            boundary;
    logic            lock_reached;
    logic            force_sync;
    logic            consume;
    logic            accept;
    logic [15:0]     sel_word;
    logic            sel_sync;

    assign boundary     = (bit_cnt == 4'd0);
    assign lock_reached = (frame_cnt == LOCK_CNT);
    assign force_sync   = (SYNC_INTERVAL != 0) && (run_cnt == RUN_MAX);
    assign cmd_ready    = out_en && !hold_full;
    assign accept       = cmd_valid && cmd_ready;

    // State register
    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) state <= PREAMBLE;
        else     state <= state_nxt;
    end

    // Next state: leave the preamble at the boundary ending the last lock frame
    always_comb begin
        state_nxt = state;
        if (state == PREAMBLE && boundary && lock_reached)
            state_nxt = RUN;
    end

    // Frame selection: forced sync, then held word, then idle sync
    always_comb begin
        sel_word = SYNC_WORD;
        sel_sync = 1'b1;
        consume  = 1'b0;
        if (state_nxt == RUN && !force_sync && hold_full) begin
            sel_word = hold_data;
            sel_sync = 1'b0;
            consume  = boundary;
        end
    end

    // Serializer, frame flags and counters
    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            out_en        <= 1'b0;
            bit_cnt       <= 4'd0;
            shreg         <= 16'd0;
            ttc_data      <= 1'b0;
            frame_start   <= 1'b0;
            frame_is_sync <= 1'b0;
            preamble_done <= 1'b0;
            frame_cnt     <= '0;
            run_cnt       <= '0;
        end else begin
            out_en  <= 1'b1;
            bit_cnt <= bit_cnt + 4'd1;
            if (boundary) begin
                shreg         <= sel_word;
                ttc_data      <= sel_word[15];
                frame_start   <= 1'b1;
                frame_is_sync <= sel_sync;
                if (state == PREAMBLE && !lock_reached)
                    frame_cnt <= frame_cnt + 1'b1;
                if (state_nxt == RUN) begin
                    preamble_done <= 1'b1;
                    run_cnt       <= sel_sync ? '0 : run_cnt + 1'b1;
                end
            end else begin
                ttc_data    <= shreg[4'd15 - bit_cnt];
                frame_start <= 1'b0;
            end
        end
    end

    // Holding register: filled on accept, emptied when its word is framed
    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= 16'd0;
        end else if (consume) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= cmd_data;
        end
    end
endmodule
